// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for receiver, transmitter and comms
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 25;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - oversampling 8N1 receiver with glitch rejection and framing-error flag
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rx_in,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      valid_out,
    output logic                      framing_error_out,
    output logic                      busy_out
);

    localparam logic [15:0] HALF     = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(UART_DATA_BITS - 1);

    logic rx_sync;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_rx_sync (
        .clk(clk_in),
        .rst(rst_in),
        .d  (rx_in),
        .q  (rx_sync)
    );

    uart_state_t               state,     state_nxt;
    logic [15:0]               cnt,       cnt_nxt;
    logic [2:0]                bit_idx,   bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [UART_DATA_BITS-1:0] data_nxt;
    logic                      valid_nxt;
    logic                      ferr_nxt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            shift_reg         <= '0;
            data_out          <= '0;
            valid_out         <= 1'b0;
            framing_error_out <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            bit_idx           <= bit_idx_nxt;
            shift_reg         <= shift_nxt;
            data_out          <= data_nxt;
            valid_out         <= valid_nxt;
            framing_error_out <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        data_nxt    = data_out;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end

            // Re-check the start bit at its centre; a short low pulse is a glitch.
            START: begin
                if (cnt == HALF - 16'd1) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_nxt[bit_idx] = rx_sync;
                    cnt_nxt            = '0;
                    bit_idx_nxt        = bit_idx + 3'd1;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end

            // Leaving at mid-stop-bit keeps half a bit of slack for a back-to-back start edge.
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_sync) begin
                        data_nxt  = shift_reg;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end

            // A held-low line (break) must not decode as a stream of 0x00 bytes.
            WAIT_HIGH: begin
                if (rx_sync) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - randomized frame stimulus against a cycle-timed event model
module tb_uart_byte_rx;

    localparam int CPB  = 25;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       rst_in;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       framing_error_out;
    logic       busy_out;

    uart_byte_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .rx_in            (rx_in),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .framing_error_out(framing_error_out),
        .busy_out         (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int lo;
        int hi;
    } iv_t;

    ev_t        evq[$];
    iv_t        ivq[$];
    logic [7:0] obs_data[$];
    int         obs_cyc[$];
    int         ferr_cnt      = 0;
    int         model_rst_cyc = -1;
    logic [7:0] model_data    = 8'h00;
    bit         run_checks    = 0;
    int         total         = 0;
    int         bad           = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    ev_t  cur_ev;
    logic exp_valid, exp_ferr, exp_busy;

    always @(negedge clk) begin
        if (run_checks) begin
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            exp_busy  = 1'b0;
            if (cyc == model_rst_cyc) begin
                evq.delete();
                ivq.delete();
                model_data = 8'h00;
            end
            if (evq.size() > 0 && evq[0].at == cyc) begin
                cur_ev = evq.pop_front();
                if (cur_ev.err) exp_ferr = 1'b1;
                else begin
                    exp_valid  = 1'b1;
                    model_data = cur_ev.data;
                end
            end
            foreach (ivq[i])
                if (cyc >= ivq[i].lo && cyc < ivq[i].hi) exp_busy = 1'b1;
            while (ivq.size() > 0 && ivq[0].hi <= cyc) void'(ivq.pop_front());

            check("valid", 32'(valid_out), 32'(exp_valid));
            check("ferr", 32'(framing_error_out), 32'(exp_ferr));
            check("data", 32'(data_out), 32'(model_data));
            check("busy", 32'(busy_out), 32'(exp_busy));

            if (valid_out) begin
                obs_data.push_back(data_out);
                obs_cyc.push_back(cyc);
            end
            if (framing_error_out) ferr_cnt++;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        model_rst_cyc = cyc + 1;
        rst_in = 1'b1;
        hold(1);
        rst_in = 1'b0;
        check("data_after_reset", 32'(data_out), 32'h00);
    endtask

    // stop_low = 0: good stop bit; otherwise stop held low for that many bit times.
    task automatic send_frame(input logic [7:0] b, input int stop_low, input int rst_bit, output int e0);
        int ev;
        e0 = cyc + 1;
        ev = e0 + 2 + HALF + 9 * CPB;
        if (stop_low == 0) begin
            evq.push_back('{ev, 1'b0, b});
            ivq.push_back('{e0 + 2, ev});
        end else begin
            evq.push_back('{ev, 1'b1, 8'h00});
            ivq.push_back('{e0 + 2, e0 + 9 * CPB + stop_low * CPB + 2});
        end
        rx_in = 1'b0;
        hold(CPB);
        for (int k = 0; k < 8; k++) begin
            rx_in = b[k];
            if (k == rst_bit) begin
                hold(CPB / 2);
                do_reset();
                hold(CPB - CPB / 2 - 1);
            end else begin
                hold(CPB);
            end
        end
        if (stop_low == 0) begin
            rx_in = 1'b1;
            hold(CPB);
        end else begin
            rx_in = 1'b0;
            hold(stop_low * CPB);
            rx_in = 1'b1;
        end
    endtask

    initial begin
        int         e0;
        int         n0;
        int         f0;
        int         gap;
        int         nerr;
        int         exp_valids;
        logic [7:0] b;
        logic [7:0] want;

        rst_in = 1'b1;
        rx_in  = 1'b1;
        hold(3);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_ferr", 32'(framing_error_out), 32'h0);
        check("rst_busy", 32'(busy_out), 32'h0);
        rst_in     = 1'b0;
        run_checks = 1;

        hold(1000);
        check("idle_valids", 32'(obs_data.size()), 32'd0);
        check("idle_busy", 32'(busy_out), 32'h0);

        send_frame(8'h36, 0, -1, e0);
        check("single_count", 32'(obs_data.size()), 32'd1);
        if (obs_data.size() == 1) begin
            check("single_data", 32'(obs_data[0]), 32'h36);
            check("single_latency", 32'(obs_cyc[0] - e0), 32'd239);
        end
        hold(10);

        n0 = obs_data.size();
        for (int i = 0; i < 19; i++) begin
            want = (i < 3) ? 8'h00 : (((i - 3) % 2 == 1) ? 8'h37 : 8'h36);
            send_frame(want, 0, -1, e0);
        end
        hold(5);
        check("b2b_count", 32'(obs_data.size() - n0), 32'd19);
        for (int i = 0; i < 19; i++) begin
            want = (i < 3) ? 8'h00 : (((i - 3) % 2 == 1) ? 8'h37 : 8'h36);
            if (n0 + i < obs_data.size()) check("b2b_byte", 32'(obs_data[n0 + i]), 32'(want));
        end

        n0 = obs_data.size();
        e0 = cyc + 1;
        ivq.push_back('{e0 + 2, e0 + 2 + HALF});
        rx_in = 1'b0;
        hold(5);
        rx_in = 1'b1;
        hold(HALF + 3);
        check("glitch_busy", 32'(busy_out), 32'h0);
        check("glitch_valids", 32'(obs_data.size() - n0), 32'd0);
        hold(20);

        n0 = obs_data.size();
        f0 = ferr_cnt;
        send_frame(8'hA5, 3, -1, e0);
        hold(CPB);
        check("ferr_count", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_data_held", 32'(data_out), 32'h37);
        check("ferr_no_bytes", 32'(obs_data.size() - n0), 32'd0);
        send_frame(8'h3C, 0, -1, e0);
        check("after_ferr_count", 32'(obs_data.size() - n0), 32'd1);
        if (obs_data.size() > 0) check("after_ferr_byte", 32'(obs_data[$]), 32'h3C);
        hold(10);

        n0 = obs_data.size();
        send_frame(8'hFF, 0, 4, e0);
        hold(10);
        check("abort_no_byte", 32'(obs_data.size() - n0), 32'd0);
        send_frame(8'h12, 0, -1, e0);
        check("post_reset_count", 32'(obs_data.size() - n0), 32'd1);
        if (obs_data.size() > 0) check("post_reset_byte", 32'(obs_data[$]), 32'h12);
        hold(10);

        n0         = obs_data.size();
        f0         = ferr_cnt;
        exp_valids = 0;
        nerr       = 0;
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                send_frame(b, int'($urandom_range(2, 4)), -1, e0);
                nerr++;
                gap = int'($urandom_range(3, 20));
            end else begin
                send_frame(b, 0, -1, e0);
                exp_valids++;
                gap = int'($urandom_range(0, 20));
            end
            hold(gap);
        end
        hold(10);
        check("rand_valids", 32'(obs_data.size() - n0), 32'(exp_valids));
        check("rand_ferrs", 32'(ferr_cnt - f0), 32'(nerr));
        check("model_drained", 32'(evq.size()), 32'd0);

        hold(50);
        run_checks = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial receive front end for the host link: oversamples the asynchronous `rx_in` line, recovers 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) and presents each good byte as a one-cycle strobe. Sits directly upstream of `comms`, which consumes the byte stream to assemble its 3-byte command headers and 64-bit data words. Start-bit glitches are rejected, and framing errors are flagged rather than delivered.

## Interface
Parameters:
- `CLKS_PER_BIT`, 25: clock cycles per bit (100 MHz clock / 4 Mbaud); legal range 4..65535.

Ports:
- `clk_in` input 1: system clock; the only clock.
- `rst_in` input 1: synchronous, active-high reset.
- `rx_in` input 1: asynchronous serial line; idle high.
- `data_out` output 8: last good byte received; holds until the next good byte.
- `valid_out` output 1: one-cycle pulse; `data_out` is new in the same cycle.
- `framing_error_out` output 1: one-cycle pulse on a stop bit sampled low.
- `busy_out` output 1: high whenever FSM state != IDLE.

## Operation
- Synchronizer: two flops on `rx_in` produce `rx_sync`; both flops reset to 1. All FSM decisions use `rx_sync` only.
- Constant `HALF = CLKS_PER_BIT/2` (floor). `cnt` is 16 bits; `bit_idx` is 3 bits.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: if `rx_sync`==0, go to START with `cnt`=0.
  - START: `cnt`++ until `cnt`==HALF-1; on that cycle sample `rx_sync`.
    - If 1: glitch; go to IDLE, no output.
    - If 0: go to DATA with `cnt`=0 and `bit_idx`=0.
  - DATA: on `cnt`==CLKS_PER_BIT-1, shift `rx_sync` into bit `bit_idx` (LSB first), set `cnt`=0, increment `bit_idx`. After bit 7, go to STOP.
  - STOP: on `cnt`==CLKS_PER_BIT-1, sample `rx_sync`.
    - If 1: load `data_out` from the shift register, pulse `valid_out`, go to IDLE.
    - If 0: pulse `framing_error_out`, leave `data_out` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_sync`==1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.
- Returning to IDLE from mid-stop-bit is intentional. It leaves half a bit of margin to catch the next start edge, so back-to-back frames with no idle gap are received.
- `valid_out` and `framing_error_out` are never high in the same cycle.
- There is no backpressure. The consumer must accept every `valid_out`, and `comms` does.

## Timing
- Reset values: `data_out`=8'h00, `valid_out`=0, `framing_error_out`=0, `busy_out`=0, state=IDLE, sync flops=1, shift register=0.
- Reset asserted mid-frame aborts the frame with no output pulse. The first start bit is recognised no earlier than 2 cycles after `rst_in` deasserts (synchronizer refill).
- Latency: let E0 be the first rising edge that registers `rx_in`=0.
  - FSM enters START at E0+2.
  - Start bit is sampled at E0+2+HALF.
  - Data bit k (k=0..7) is sampled at E0+2+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit is sampled at E0+2+HALF+9·CLKS_PER_BIT; `valid_out` is high for the cycle following that edge.
  - With the default of 25: `valid_out` is high in cycle E0+239.
- `busy_out` rises at E0+2 and falls together with the `valid_out` or `framing_error_out` pulse. After a framing error it stays high until the line returns high.
- Baud tolerance: sampling at mid-bit gives ±~4.5 % cumulative error over 10 bits.

## Structure
- Shared package `uart_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - `UART_CLKS_PER_BIT_DEFAULT` = 25.
  - `UART_DATA_BITS` = 8.
- The package is shared with the future transmitter and with `comms`.
- Sub-module `sync_2ff` (parameterised reset value, here 1) for the input synchronizer; reusable elsewhere. Everything else stays in one always_ff FSM plus counters.

## Test plan
- Reset then idle: `rx_in`=1 for 1000 cycles → all outputs stay 0; `busy_out`=0.
- Single frame 0x36 at 250 ns/bit (10 ns clock) → exactly one `valid_out` pulse with `data_out`=8'h36, E0+239 cycles after the start edge; `framing_error_out` never pulses.
- Back-to-back stream: 3 header bytes 0x00, then 16 data bytes alternating 0x36/0x37, with no idle gap → 19 `valid_out` pulses in order with correct values; no errors.
- Glitch: `rx_in` low for 5 cycles, then high → no pulse; `busy_out` returns to 0 within HALF+3 cycles.
- Framing error: frame 0xA5 with the stop bit held low for 3 bit times, then high, then frame 0x3C → one `framing_error_out` pulse; `data_out` stays at its previous value; then `valid_out` with 8'h3C. No spurious 0x00 bytes are produced.
- Reset mid-frame: assert `rst_in` for 1 cycle during data bit 4 of 0xFF, then send 0x12 → no output for 0xFF; `valid_out` with 8'h12; `data_out`=8'h00 immediately after reset.
